// File: rtl/rr_arbiter_oh.sv
// Round-robin arbiter with one-hot grant and valid/ready handshake; the pointer advances only on a transfer.
// Define RR_ARB_LOCK_EN to hold the presented grant stable while the downstream applies backpressure.
module rr_arbiter_oh #(
    parameter int InputWidth = 8,
    parameter int IdxWidth   = (InputWidth > 1) ? $clog2(InputWidth) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [InputWidth-1:0] req_i,
    output logic [InputWidth-1:0] gnt_o,
    output logic [IdxWidth-1:0]   gnt_idx_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    logic [IdxWidth-1:0]   ptr_reg;
    logic [IdxWidth-1:0]   ptr_next;
    logic [IdxWidth-1:0]   sel_idx;
    logic [InputWidth-1:0] win_oh;
    logic [InputWidth-1:0] grant_raw;
    logic                  valid_raw;
    logic                  xfer;

    // First set request scanning upward from the pointer, wrapping explicitly past the top index.
    always_comb begin : winner_scan
        int   cand;
        logic found;
        win_oh = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < InputWidth; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= InputWidth) begin
                cand = cand - InputWidth;
            end
            if (!found && req_i[cand]) begin
                win_oh[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end

`ifdef RR_ARB_LOCK_EN
    logic                  lock_reg;
    logic [InputWidth-1:0] held_reg;

    assign grant_raw = lock_reg ? held_reg : win_oh;
    assign valid_raw = lock_reg | (|req_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_reg <= 1'b0;
            held_reg <= '0;
        end else if (xfer) begin
            lock_reg <= 1'b0;
        end else if (valid_o) begin
            lock_reg <= 1'b1;
            held_reg <= gnt_o;
        end
    end
`else
    assign grant_raw = win_oh;
    assign valid_raw = |req_i;
`endif

    // Outputs are forced idle for the whole reset cycle, discarding any held grant.
    assign gnt_o   = rst_i ? '0 : grant_raw;
    assign valid_o = !rst_i && valid_raw;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < InputWidth; i++) begin
            if (gnt_o[i]) begin
                sel_idx = IdxWidth'(i);
            end
        end
    end

    assign gnt_idx_o = sel_idx;
    assign xfer      = valid_o && ready_i;
    assign ptr_next  = (sel_idx == IdxWidth'(InputWidth - 1)) ? '0 : sel_idx + IdxWidth'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else if (xfer) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule
